// File: rtl/tdm_demux_if.sv
// Bundles the sample input and frame output of the TDM receive demultiplexer.
// Handshake: din is consumed on every clk edge where din_valid=1 (no backpressure);
// dout is qualified by the one-cycle dout_valid pulse and holds until the next commit.
interface tdm_demux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               din_sync;
    logic [4*WIDTH-1:0] dout;
    logic               dout_valid;
    logic [1:0]         sel;
    logic               locked;
    logic               frame_err;
    logic               state_dbg;

    modport master (
        output din, din_valid, din_sync,
        input  dout, dout_valid, sel, locked, frame_err, state_dbg
    );

    modport slave (
        input  din, din_valid, din_sync,
        output dout, dout_valid, sel, locked, frame_err, state_dbg
    );
endinterface

// File: rtl/tdm_demux.sv
// 4-channel TDM receive demultiplexer: locks to frame sync, assembles
// four samples and presents each complete frame as one registered word.
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    tdm_demux_if.slave  bus
);
    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t             state;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   slot0, slot1, slot2;
    logic [4*WIDTH-1:0] dout;
    logic               dout_valid;
    logic               frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sel        <= 2'd0;
            slot0      <= '0;
            slot1      <= '0;
            slot2      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.din_sync) begin
                            slot0 <= bus.din;
                            sel   <= 2'd1;
                            state <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (sel == 2'd0) begin
                            if (bus.din_sync) begin
                                slot0 <= bus.din;
                                sel   <= 2'd1;
                            end else begin
                                frame_err <= 1'b1;
                                sel       <= 2'd0;
                                state     <= HUNT;
                            end
                        end else if (bus.din_sync) begin
                            // Early sync restarts the frame with this sample as ch0.
                            frame_err <= 1'b1;
                            slot0     <= bus.din;
                            slot1     <= '0;
                            slot2     <= '0;
                            sel       <= 2'd1;
                        end else begin
                            case (sel)
                                2'd1:    slot1 <= bus.din;
                                2'd2:    slot2 <= bus.din;
                                default: begin
                                    dout       <= {bus.din, slot2, slot1, slot0};
                                    dout_valid <= 1'b1;
                                end
                            endcase
                            sel <= sel + 2'd1;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        sel   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.sel        = sel;
    assign bus.locked     = (state == LOCK);
    assign bus.frame_err  = frame_err;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios then random traffic, checked every
// cycle against a queue-based frame model and an expected-frame scoreboard.
module tb_tdm_demux;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    tdm_demux_if #(.WIDTH(W)) bus ();

    tdm_demux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: samples of the frame being assembled, plus sync status
    logic [W-1:0]   frame_q[$];
    logic [4*W-1:0] exp_q[$];
    bit             m_locked = 1'b0;
    logic [4*W-1:0] m_dout   = '0;
    bit             m_dv     = 1'b0;
    bit             m_fe     = 1'b0;

    task automatic check(input string tag, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        m_dv = 1'b0;
        m_fe = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            frame_q.delete();
            m_dout = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    frame_q = {d};
                    m_locked = 1'b1;
                end
            end else if (frame_q.size() == 0) begin
                if (s) frame_q = {d};
                else begin
                    m_fe = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (s) begin
                m_fe = 1'b1;
                frame_q = {d};
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == 4) begin
                    m_dout = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
                    m_dv = 1'b1;
                    exp_q.push_back(m_dout);
                    frame_q.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        rst           = r;
        bus.din_valid = v;
        bus.din_sync  = s;
        bus.din       = d;
        @(posedge clk);
        #1;
        model(r, v, s, d);
        check("dout", bus.dout, m_dout);
        check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, m_dv});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_fe});
        check("locked", {31'd0, bus.locked}, {31'd0, m_locked});
        check("sel", {30'd0, bus.sel}, 32'(frame_q.size()));
        if (bus.dout_valid) begin
            if (exp_q.size() == 0) check("sb_unexpected_frame", 32'd1, 32'd0);
            else check("sb_frame", bus.dout, exp_q.pop_front());
        end
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.din_sync = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        check("reset_dout", bus.dout, 32'h0);
        check("reset_sel", {30'd0, bus.sel}, 32'd0);

        // Clean frame
        step(1'b0, 1'b1, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b0, 8'h44);
        check("t1_dout", bus.dout, 32'h44332211);
        check("t1_dv", {31'd0, bus.dout_valid}, 32'd1);
        gap();
        check("t1_dv_one_cycle", {31'd0, bus.dout_valid}, 32'd0);

        // Early sync at sel=2 restarts the frame
        step(1'b0, 1'b1, 1'b1, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b1, 8'h03);
        check("t3_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("t3_sel", {30'd0, bus.sel}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h04);
        step(1'b0, 1'b1, 1'b0, 8'h05);
        step(1'b0, 1'b1, 1'b0, 8'h06);
        check("t3_dout", bus.dout, 32'h06050403);

        // Sync on sel=3 is an error, not a commit
        step(1'b0, 1'b1, 1'b1, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h20);
        step(1'b0, 1'b1, 1'b0, 8'h30);
        step(1'b0, 1'b1, 1'b1, 8'h40);
        check("sel3_sync_no_commit", bus.dout, 32'h06050403);
        step(1'b0, 1'b1, 1'b0, 8'h50);
        step(1'b0, 1'b1, 1'b0, 8'h60);
        step(1'b0, 1'b1, 1'b0, 8'h70);
        check("sel3_restart_dout", bus.dout, 32'h70605040);

        // Missing sync at sel=0 drops lock
        step(1'b0, 1'b1, 1'b0, 8'h77);
        check("t4_locked", {31'd0, bus.locked}, 32'd0);
        check("t4_dout_held", bus.dout, 32'h70605040);

        // Hunting ignores unsynced samples
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 1'b0, 8'hBB);
        check("t2_no_err", {31'd0, bus.frame_err}, 32'd0);

        // Frames with gaps, then back-to-back frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 1'b1, i == 0, W'($urandom));
                repeat ($urandom_range(0, 2)) gap();
            end
        end
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i == 0, W'($urandom));

        // Reset mid-frame at sel=2
        step(1'b0, 1'b1, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b1, 1'b0, 8'hC3);
        check("t6_dout", bus.dout, 32'h0);
        check("t6_sel", {30'd0, bus.sel}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 8'hD1);
        step(1'b0, 1'b1, 1'b0, 8'hD2);
        step(1'b0, 1'b1, 1'b0, 8'hD3);
        step(1'b0, 1'b1, 1'b0, 8'hD4);
        check("t6_dout_after", bus.dout, 32'hD4D3D2D1);

        // Random traffic: mostly well-formed with occasional sync faults
        for (int i = 0; i < 600; i++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = (frame_q.size() == 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 199) == 0, v, s, W'($urandom));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
